// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: access size encoding, FSM states, alignment helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. The ACC1 state exists only when DMEM_LSU_MISALIGN_EN is defined.
package dmem_lsu_pkg;

  // Access size as carried on req_size; 2'b11 is the illegal encoding
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // Control states; ACC1 is the second beat of a split misaligned access
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ERR  = 2'b10
`ifdef DMEM_LSU_MISALIGN_EN
    , ACC1 = 2'b11
`endif
  } state_e;

  function automatic logic is_illegal(input logic [1:0] size);
    return size == 2'b11;
  endfunction

  // Half on an odd byte, or word off a word boundary, straddles two lanes groups
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte-enable/data placement and load extract/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [7:0]  st_mask,
  output logic [63:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [63:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [3:0]  base_mask;
  logic [31:0] ld_shift;
  logic        ext;

  // Store side: mask/data over two adjacent words so a straddling access can take the high half
  always_comb begin
    base_mask = 4'b1111;
    case (st_size)
      SZ_BYTE: base_mask = 4'b0001;
      SZ_HALF: base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    st_mask = {4'b0000, base_mask} << st_off;
    if (st_size == SZ_BYTE)
      st_data = {32'h0, {4{st_wdata[7:0]}}};
    else
      st_data = {32'h0, st_wdata} << {st_off, 3'b000};
  end

  // Load side: shift the addressed byte to lane 0, then truncate and extend
  always_comb begin
    ld_shift = 32'(ld_raw >> {ld_off, 3'b000});
    ext      = ~ld_unsigned;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ext & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{ext & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed core requests onto a word-wide memory; DMEM_LSU_MISALIGN_EN enables split misaligned accesses.
// Latency: aligned response 1 cycle after acceptance; rejected access and split access respond 2 cycles after acceptance.
// Backpressure: req_ready is high only in IDLE, so a single access is in flight at any time.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_enable,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  state_e      state_q, state_d;
  logic [1:0]  size_q, off_q;
  logic        uns_q, we_q, err_arm_q;
  logic        accept, reject;
  logic [1:0]  req_off;
  logic [1:0]  st_size, st_off;
  logic [31:0] st_wdata;
  logic [7:0]  st_mask;
  logic [63:0] st_data;
  logic [63:0] ld_raw;
  logic [31:0] ld_data;
  logic        unused_addr;

  assign req_off     = req_addr[1:0];
  assign req_ready   = resetn && (state_q == IDLE);
  assign accept      = req_ready && req_valid;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

`ifdef DMEM_LSU_MISALIGN_EN
  logic              split, split_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q, q0_q;

  assign split    = is_misaligned(req_size, req_off) && !is_illegal(req_size);
  assign reject   = is_illegal(req_size);
  // The second beat re-steers from the registered request, not the live port
  assign st_size  = (state_q == IDLE) ? req_size  : size_q;
  assign st_off   = (state_q == IDLE) ? req_off   : off_q;
  assign st_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign ld_raw   = (state_q == ACC1) ? {mem_q, q0_q} : {32'h0, mem_q};
`else
  logic unused_hi;

  assign reject    = is_illegal(req_size) || is_misaligned(req_size, req_off);
  assign st_size   = req_size;
  assign st_off    = req_off;
  assign st_wdata  = req_wdata;
  assign ld_raw    = {32'h0, mem_q};
  assign unused_hi = ^{st_mask[7:4], st_data[63:32]};
`endif

  lsu_align u_align (
    .st_size     (st_size),
    .st_off      (st_off),
    .st_wdata    (st_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .ld_raw      (ld_raw),
    .ld_data     (ld_data)
  );

  // Memory strobes: first beat straight from the port on acceptance, second beat from registered fields
  always_comb begin
    mem_enable  = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_byteena = 4'b0000;
    mem_data    = 32'h0;
    if (accept && !reject) begin
      mem_enable  = 1'b1;
      mem_wren    = req_we;
      mem_address = req_addr[ADDR_W+1:2];
      mem_byteena = req_we ? st_mask[3:0] : 4'b1111;
      mem_data    = st_data[31:0];
    end
`ifdef DMEM_LSU_MISALIGN_EN
    if ((state_q == ACC0) && split_q) begin
      mem_enable  = 1'b1;
      mem_wren    = we_q;
      mem_address = word_q + 1'b1;
      mem_byteena = we_q ? st_mask[7:4] : 4'b1111;
      mem_data    = st_data[63:32];
    end
`endif
  end

  // Response pulse; stores and errors return zero data
  always_comb begin
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (state_q)
      ACC0: begin
`ifdef DMEM_LSU_MISALIGN_EN
        resp_valid = !split_q;
`else
        resp_valid = 1'b1;
`endif
        if (resp_valid && !we_q) resp_rdata = ld_data;
      end
`ifdef DMEM_LSU_MISALIGN_EN
      ACC1: begin
        resp_valid = 1'b1;
        if (!we_q) resp_rdata = ld_data;
      end
`endif
      ERR: begin
        resp_valid = err_arm_q;
        resp_err   = err_arm_q;
      end
      default: ;
    endcase
  end

  // Next-state: ERR holds one silent cycle before reporting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = reject ? ERR : ACC0;
`ifdef DMEM_LSU_MISALIGN_EN
      ACC0: state_d = split_q ? ACC1 : IDLE;
      ACC1: state_d = IDLE;
`else
      ACC0: state_d = IDLE;
`endif
      ERR:  if (err_arm_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured request fields; reset aborts any access in flight
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      err_arm_q <= 1'b0;
`ifdef DMEM_LSU_MISALIGN_EN
      split_q   <= 1'b0;
      word_q    <= '0;
      wdata_q   <= 32'h0;
      q0_q      <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      err_arm_q <= (state_q == ERR) && !err_arm_q;
      if (accept) begin
        size_q <= req_size;
        off_q  <= req_off;
        uns_q  <= req_unsigned;
        we_q   <= req_we;
`ifdef DMEM_LSU_MISALIGN_EN
        split_q <= split;
        word_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
`endif
      end
`ifdef DMEM_LSU_MISALIGN_EN
      if (state_q == ACC0) q0_q <= mem_q;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed requests push expected responses; a monitor checks them.
// Latency: expected response cycle is tracked per request.
// Backpressure: requests wait (bounded) for req_ready before issuing.
module tb_dmem_lsu;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              resetn;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]       req_addr, req_wdata;
  logic [1:0]        req_size;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteena;
  logic [31:0]       mem_data;
  logic              mem_enable, mem_wren;
  logic [31:0]       mem_q = 32'h0;

  always #5 clock = ~clock;

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_data(mem_data), .mem_enable(mem_enable), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  // Memory model with a preload side port
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pl_vld = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_dat = 32'h0;

  always @(posedge clock) begin
    if (pl_vld) mem[pl_addr] <= pl_dat;
    else if (mem_enable && mem_wren)
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i]) mem[mem_address][8*i +: 8] <= mem_data[8*i +: 8];
    if (mem_enable && !mem_wren) mem_q <= mem[mem_address];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic              cap_en, cap_we;
  logic [3:0]        cap_be;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_dat;
  int                acc_cyc, prev_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (resetn && resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: got response rdata=%h err=%b, expected none", resp_rdata, resp_err);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pl_addr = a; pl_dat = d; pl_vld = 1'b1;
    @(posedge clock); #1;
    pl_vld = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input bit push);
    int   n;
    exp_t e;
    req_addr = addr; req_we = we; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL ready_timeout: req_ready=0, expected 1 within 20 cycles");
    end
    cap_en = mem_enable; cap_we = mem_wren; cap_be = mem_byteena;
    cap_addr = mem_address; cap_dat = mem_data;
    prev_acc = acc_cyc; acc_cyc = cyc;
    if (push) begin
      e.rdata = exp_rd; e.err = exp_err; e.due = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    // Scramble the port so any use of live fields after acceptance shows up
    req_valid = 1'b0; req_addr = ~addr; req_we = ~we; req_size = ~size;
    req_unsigned = ~uns; req_wdata = ~wdata;
  endtask

  initial begin
    resetn = 1'b0; acc_cyc = 0; prev_acc = 0;
    req_valid = 1'b1; req_addr = 32'h6; req_we = 1'b1; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'hA5;
    @(negedge clock);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
    chk("rst_mem_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_mem_byteena", {28'h0, mem_byteena}, 32'h0);
    chk("rst_mem_address", {20'h0, mem_address}, 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    preload(12'h000, 32'h8001_1234);
    preload(12'h001, 32'h0000_0000);
    preload(12'h002, 32'h0000_0000);
    preload(12'h003, 32'h0000_0000);
    req_valid = 1'b0;
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);
    @(posedge clock); #1;

    // Byte store 0xA5 at 0x6
    issue(32'h6, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, 32'h0, 1'b0, 1, 1'b1);
    chk("sb_byteena", {28'h0, cap_be}, 32'h4);
    chk("sb_data", cap_dat, 32'hA5A5_A5A5);
    chk("sb_address", {20'h0, cap_addr}, 32'h1);
    chk("sb_wren", {31'h0, cap_we}, 32'h1);
    chk("sb_enable", {31'h0, cap_en}, 32'h1);

    // Half loads at 0x2 from 0x80011234
    issue(32'h2, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 1, 1'b1);
    chk("lh_byteena", {28'h0, cap_be}, 32'hF);
    chk("lh_wren", {31'h0, cap_we}, 32'h0);
    issue(32'h2, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_8001, 1'b0, 1, 1'b1);
    issue(32'h0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 1, 1'b1);
    issue(32'h1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0012, 1'b0, 1, 1'b1);
    issue(32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 1, 1'b1);

    // Read back the stored byte
    issue(32'h6, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0, 1, 1'b1);
    issue(32'h6, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00A5, 1'b0, 1, 1'b1);
    issue(32'h7, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1, 1'b1);

    // Half store 0xBEEF at 0xA, word store at 0xC
    issue(32'hA, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0, 1, 1'b1);
    chk("sh_byteena", {28'h0, cap_be}, 32'hC);
    chk("sh_data", cap_dat, 32'hBEEF_0000);
    issue(32'h8, 1'b0, 2'b10, 1'b0, 32'h0, 32'hBEEF_0000, 1'b0, 1, 1'b1);
    issue(32'hA, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0, 1, 1'b1);
    issue(32'hB, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_00BE, 1'b0, 1, 1'b1);
    issue(32'hC, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1'b1);
    chk("sw_byteena", {28'h0, cap_be}, 32'hF);
    chk("sw_data", cap_dat, 32'hCAFE_F00D);
    chk("sw_address", {20'h0, cap_addr}, 32'h3);
    issue(32'hC, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b1);

    // Illegal size: rejected in every build
    issue(32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 2, 1'b1);
    chk("ill_no_access", {31'h0, cap_en}, 32'h0);
    issue(32'h4, 1'b1, 2'b11, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 2, 1'b1);
    chk("ill_st_no_access", {31'h0, cap_en}, 32'h0);

`ifndef DMEM_LSU_MISALIGN_EN
    // Misaligned word and half are rejected without touching memory
    issue(32'h1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 2, 1'b1);
    chk("mis_w_no_access", {31'h0, cap_en}, 32'h0);
    @(negedge clock);
    chk("mis_w_err_cycle_no_access", {31'h0, mem_enable}, 32'h0);
    issue(32'h3, 1'b1, 2'b01, 1'b0, 32'hFFFF, 32'h0, 1'b1, 2, 1'b1);
    chk("mis_h_no_access", {31'h0, cap_en}, 32'h0);
`else
    // Split word load across words 0 and 1
    preload(12'h000, 32'h1122_3344);
    preload(12'h001, 32'h5566_7788);
    issue(32'h3, 1'b0, 2'b10, 1'b0, 32'h0, 32'h6677_8811, 1'b0, 2, 1'b1);
    chk("split_ld_addr0", {20'h0, cap_addr}, 32'h0);
    chk("split_ld_en0", {31'h0, cap_en}, 32'h1);
    @(negedge clock);
    chk("split_ld_addr1", {20'h0, mem_address}, 32'h1);
    chk("split_ld_en1", {31'h0, mem_enable}, 32'h1);
    // Split word store wrapping from 0xFFF to 0x000
    issue(32'h3FFF, 1'b1, 2'b10, 1'b0, 32'hAABB_CCDD, 32'h0, 1'b0, 2, 1'b1);
    chk("split_st_be0", {28'h0, cap_be}, 32'h8);
    chk("split_st_addr0", {20'h0, cap_addr}, 32'hFFF);
    chk("split_st_dat0", cap_dat, 32'hDD00_0000);
    @(negedge clock);
    chk("split_st_be1", {28'h0, mem_byteena}, 32'h7);
    chk("split_st_addr1", {20'h0, mem_address}, 32'h0);
    chk("split_st_dat1", mem_data, 32'h00AA_BBCC);
    preload(12'h000, 32'h8001_1234);
`endif

    // Reset during ACC0 aborts silently
    issue(32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1, 1'b0);
    resetn = 1'b0;
    @(negedge clock);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("abort_req_ready", {31'h0, req_ready}, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    chk("abort_mem_enable", {31'h0, mem_enable}, 32'h0);
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    @(posedge clock); #1;

    // Back-to-back requests accepted every two cycles
    issue(32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 1, 1'b1);
    issue(32'h8, 1'b0, 2'b10, 1'b0, 32'h0, 32'hBEEF_0000, 1'b0, 1, 1'b1);
    chk("b2b_spacing1", acc_cyc - prev_acc, 32'd2);
    issue(32'hC, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b1);
    chk("b2b_spacing2", acc_cyc - prev_acc, 32'd2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
